// File: rtl/shift_seq_pkg.sv
// ---------------------------------------------------------------------------
// shift_seq_pkg
// Shared types and helpers for the shift_cmd_sequencer slice.
//   ctrl_e    : control encoding driven onto shift_register.ctrl
//   state_e   : sequencer FSM states
//   sat_count : clamps a requested shift count to the register width
// ---------------------------------------------------------------------------
package shift_seq_pkg;

  typedef enum logic [1:0] {
    HOLD        = 2'b00,
    SHIFT_RIGHT = 2'b01,
    SHIFT_LEFT  = 2'b10,
    LOAD        = 2'b11
  } ctrl_e;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    LOAD_S  = 2'b01,
    SHIFT_S = 2'b10,
    DONE_S  = 2'b11
  } state_e;

  // Shifting more than the width just empties the register, so larger
  // requests are clamped instead of being allowed to wrap the counter.
  function automatic int unsigned sat_count(input int unsigned count,
                                            input int unsigned limit);
    return (count > limit) ? limit : count;
  endfunction

endpackage

// File: rtl/shift_seq_cmd_buf.sv
// ---------------------------------------------------------------------------
// shift_seq_cmd_buf
// One-deep valid/ready holding register for a packed shift job. Used by
// shift_cmd_sequencer only when SHIFT_SEQ_PREFETCH_EN is defined.
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   in_valid/in_ready/in_data    : write side (ready while empty)
//   out_valid/out_ready/out_data : read side (valid while full)
// ---------------------------------------------------------------------------
module shift_seq_cmd_buf #(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // Only ever holds one entry, so a push can never coincide with a pop.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (out_valid && out_ready) begin
      valid_d = 1'b0;
    end
    if (in_valid && in_ready) begin
      valid_d = 1'b1;
      data_d  = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign in_ready  = !valid_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/shift_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// shift_cmd_sequencer
// Accepts one shift job per valid/ready handshake and drives a downstream
// shift_register: parallel load, shift count cycles, then hold with a
// one-cycle done pulse.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   in_valid, in_ready  : job handshake
//   in_data, in_dir, in_count : word, direction (1=right), shift count
//   ctrl, data          : to shift_register.ctrl / .data (registered)
//   busy, done          : job in flight / job complete pulse (registered)
// Build option:
//   SHIFT_SEQ_PREFETCH_EN : adds a one-entry command buffer so the next job
//                           can be taken while one is running and loaded
//                           straight after DONE.
// ---------------------------------------------------------------------------
module shift_cmd_sequencer
  import shift_seq_pkg::*;
#(
  parameter int N  = 8,
  parameter int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic          in_dir,
  input  logic [CW-1:0] in_count,
  output logic [1:0]    ctrl,
  output logic [N-1:0]  data,
  output logic          busy,
  output logic          done
);

  state_e        state_q, state_d;
  logic [N-1:0]  word_q, word_d;
  logic          dir_q, dir_d;
  logic [CW-1:0] cnt_q, cnt_d;

  ctrl_e         ctrl_q, ctrl_d;
  logic [N-1:0]  data_q, data_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [CW-1:0] in_cnt_sat;
  logic          accept;

  assign in_cnt_sat = CW'(sat_count(32'(in_count), 32'(N)));
  assign accept     = in_valid && in_ready;

`ifdef SHIFT_SEQ_PREFETCH_EN
  localparam int JW = N + 1 + CW;

  logic          buf_in_valid;
  logic          buf_in_ready;
  logic          buf_out_valid;
  logic          buf_pop;
  logic [JW-1:0] buf_out_data;

  // A job offered while one is in flight goes to the buffer instead.
  assign in_ready     = !reset && ((state_q == IDLE) ||
                        (((state_q == LOAD_S) || (state_q == SHIFT_S)) && buf_in_ready));
  assign buf_in_valid = accept && (state_q != IDLE);

  shift_seq_cmd_buf #(
    .W(JW)
  ) u_cmd_buf (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (buf_in_valid),
    .in_ready  (buf_in_ready),
    .in_data   ({in_dir, in_cnt_sat, in_data}),
    .out_valid (buf_out_valid),
    .out_ready (buf_pop),
    .out_data  (buf_out_data)
  );
`else
  assign in_ready = !reset && (state_q == IDLE);
`endif

  // Next-state and job register logic. cnt_q holds the shifts still to do,
  // so SHIFT exits on the cycle it would reach zero.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
`ifdef SHIFT_SEQ_PREFETCH_EN
    buf_pop = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = LOAD_S;
          word_d  = in_data;
          dir_d   = in_dir;
          cnt_d   = in_cnt_sat;
        end
      end
      LOAD_S: begin
        state_d = (cnt_q != '0) ? SHIFT_S : DONE_S;
      end
      SHIFT_S: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE_S;
        end
      end
      DONE_S: begin
`ifdef SHIFT_SEQ_PREFETCH_EN
        if (buf_out_valid) begin
          state_d                 = LOAD_S;
          {dir_d, cnt_d, word_d}  = buf_out_data;
          buf_pop                 = 1'b1;
        end else begin
          state_d = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they can be registered and
  // still line up with the state they describe.
  always_comb begin
    ctrl_d = HOLD;
    data_d = data_q;
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE_S);
    case (state_d)
      LOAD_S: begin
        ctrl_d = LOAD;
        data_d = word_d;
      end
      SHIFT_S: begin
        ctrl_d = dir_d ? SHIFT_RIGHT : SHIFT_LEFT;
      end
      default: begin
        ctrl_d = HOLD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      word_q  <= '0;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
      ctrl_q  <= HOLD;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ctrl = ctrl_q;
  assign data = data_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_shift_cmd_sequencer
// Directed bench for shift_cmd_sequencer with a behavioural shift_register
// chained on ctrl/data so the final word can be checked at done.
// ---------------------------------------------------------------------------
module tb_shift_cmd_sequencer;

  logic       clk;
  logic       reset;
  logic       inValid;
  logic       inReady;
  logic [7:0] inData;
  logic       inDir;
  logic [3:0] inCount;
  logic [1:0] ctrl;
  logic [7:0] data;
  logic       busy;
  logic       done;

  logic [7:0] qReg;
  int         checks;
  int         failures;

  shift_cmd_sequencer #(.N(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (inValid),
    .in_ready (inReady),
    .in_data  (inData),
    .in_dir   (inDir),
    .in_count (inCount),
    .ctrl     (ctrl),
    .data     (data),
    .busy     (busy),
    .done     (done)
  );

  // Free-running clock, 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream shift_register: LOAD / right / left / hold, zero fill.
  always @(posedge clk) begin
    case (ctrl)
      2'b11:   qReg <= data;
      2'b01:   qReg <= {1'b0, qReg[7:1]};
      2'b10:   qReg <= {qReg[6:0], 1'b0};
      default: qReg <= qReg;
    endcase
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Offer a job and complete the handshake; returns one cycle after it.
  task automatic applyStimulus(input logic [7:0] d, input logic dir,
                               input logic [3:0] cnt);
    int waited;
    inData  = d;
    inDir   = dir;
    inCount = cnt;
    inValid = 1'b1;
    waited  = 0;
    while (!inReady && waited < 100) begin
      tick();
      waited++;
    end
    if (waited >= 100) checkOutput("ready_timeout", 32'd0, 32'd1);
    tick();
    inValid = 1'b0;
  endtask

  // Run a job and check every cycle from LOAD through DONE and back to IDLE.
  task automatic runJob(input string tag, input logic [7:0] d, input logic dir,
                        input logic [3:0] cnt, input int expShifts,
                        input logic [7:0] expQ);
    int expCtrl;
    applyStimulus(d, dir, cnt);
    // Scribble on the inputs to show they are not resampled mid-job.
    inData  = ~d;
    inDir   = ~dir;
    inCount = 4'd1;
    for (int i = 0; i < expShifts + 2; i++) begin
      if (i == 0)              expCtrl = 3;
      else if (i <= expShifts) expCtrl = dir ? 1 : 2;
      else                     expCtrl = 0;
      checkOutput({tag, "_ctrl"}, 32'(ctrl), 32'(expCtrl));
      checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
      checkOutput({tag, "_done"}, 32'(done), 32'(i == expShifts + 1));
      if (i == 0) checkOutput({tag, "_data"}, 32'(data), 32'(d));
      if (i == expShifts + 1) checkOutput({tag, "_q"}, 32'(qReg), 32'(expQ));
      tick();
    end
    checkOutput({tag, "_idle_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_idle_ready"}, 32'(inReady), 32'd1);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    inValid  = 1'b0;
    inData   = 8'h00;
    inDir    = 1'b0;
    inCount  = 4'd0;

    // Reset held for 20 cycles: everything quiet, no handshake possible.
    for (int i = 0; i < 20; i++) begin
      tick();
      checkOutput("rst_ctrl", 32'(ctrl), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_ready", 32'(inReady), 32'd0);
    end
    reset = 1'b0;
    #1;
    checkOutput("post_rst_ready", 32'(inReady), 32'd1);
    tick();
    checkOutput("post_rst_ctrl", 32'(ctrl), 32'd0);
    checkOutput("post_rst_busy", 32'(busy), 32'd0);
    checkOutput("post_rst_done", 32'(done), 32'd0);
    checkOutput("post_rst_data", 32'(data), 32'd0);

    // Left shift by 3: 01010101 -> 10101000.
    runJob("left3", 8'b01010101, 1'b0, 4'd3, 3, 8'b10101000);
    // Zero count: LOAD then DONE, word unchanged.
    runJob("zero", 8'b00001111, 1'b1, 4'd0, 0, 8'b00001111);
    // Saturated count: 8 shifts empty the register.
    runJob("sat15", 8'hFF, 1'b0, 4'd15, 8, 8'h00);
    // Exact width right shift and a single right shift.
    runJob("right8", 8'hFF, 1'b1, 4'd8, 8, 8'h00);
    runJob("right1", 8'h80, 1'b1, 4'd1, 1, 8'h40);

    // Reset during the second SHIFT cycle of a count=5 job.
    applyStimulus(8'hF0, 1'b1, 4'd5);
    checkOutput("mid_load_ctrl", 32'(ctrl), 32'd3);
    tick();
    checkOutput("mid_s1_ctrl", 32'(ctrl), 32'd1);
    tick();
    checkOutput("mid_s2_ctrl", 32'(ctrl), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_ready", 32'(inReady), 32'd0);
    tick();
    checkOutput("mid_rst_ctrl", 32'(ctrl), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checkOutput("mid_nodone", 32'(done), 32'd0);
    end
    runJob("after_rst", 8'h81, 1'b1, 4'd2, 2, 8'h20);

    // Two jobs offered back to back: A (0x55 left 2), then B (0x3C right 1).
    applyStimulus(8'h55, 1'b0, 4'd2);
    inData  = 8'h3C;
    inDir   = 1'b1;
    inCount = 4'd1;
    inValid = 1'b1;
`ifdef SHIFT_SEQ_PREFETCH_EN
    checkOutput("b2b_load_ready", 32'(inReady), 32'd1);
    tick();
    inValid = 1'b0;
    checkOutput("b2b_s1_ready", 32'(inReady), 32'd0);
    checkOutput("b2b_s1_ctrl", 32'(ctrl), 32'd2);
    tick();
    checkOutput("b2b_s2_ctrl", 32'(ctrl), 32'd2);
    tick();
    checkOutput("b2b_a_done", 32'(done), 32'd1);
    checkOutput("b2b_a_q", 32'(qReg), 32'h54);
    tick();
    checkOutput("b2b_b_ctrl_load", 32'(ctrl), 32'd3);
    checkOutput("b2b_b_busy", 32'(busy), 32'd1);
    checkOutput("b2b_b_data", 32'(data), 32'h3C);
`else
    for (int i = 0; i < 4; i++) begin
      checkOutput("b2b_busy_ready", 32'(inReady), 32'd0);
      if (i == 3) begin
        checkOutput("b2b_a_done", 32'(done), 32'd1);
        checkOutput("b2b_a_q", 32'(qReg), 32'h54);
      end
      tick();
    end
    checkOutput("b2b_gap_busy", 32'(busy), 32'd0);
    checkOutput("b2b_gap_ctrl", 32'(ctrl), 32'd0);
    checkOutput("b2b_gap_ready", 32'(inReady), 32'd1);
    tick();
    inValid = 1'b0;
    checkOutput("b2b_b_ctrl_load", 32'(ctrl), 32'd3);
    checkOutput("b2b_b_data", 32'(data), 32'h3C);
`endif
    tick();
    checkOutput("b2b_b_ctrl_shift", 32'(ctrl), 32'd1);
    tick();
    checkOutput("b2b_b_done", 32'(done), 32'd1);
    checkOutput("b2b_b_q", 32'(qReg), 32'h1E);
    tick();
    checkOutput("b2b_end_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
